// File: rtl/score_keeper.sv
// Score accumulator with saturation and a dirty-flag driven redraw handshake.
// Optional high-score register: define SCORE_KEEPER_HIGHSCORE_EN to enable it.
module score_keeper #(
  parameter logic [14:0] MAX_SCORE    = 15'd9999,
  parameter logic [9:0]  DONE_TIMEOUT = 10'd1023
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        hit,
  input  logic [1:0]  hitType,
  input  logic        clear,
  input  logic        done,
  output logic [14:0] scoreOut,
  output logic [14:0] highScoreOut,
  output logic        draw,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t      state_reg;
  logic [14:0] score_reg;
  logic [14:0] score_next;
  logic        dirty_reg;
  logic [9:0]  timer_reg;
  logic        draw_reg;
  logic        busy_reg;
  logic [15:0] points;
  logic [15:0] sum;
  logic        accept;
  logic        timed_out;

  assign accept    = hit | clear;
  assign timed_out = (state_reg == WAIT) && !done && (timer_reg == 10'd0);

  // 16-bit sum so the saturation compare sees the true total.
  always_comb begin
    case (hitType)
      2'd0:    points = 16'd10;
      2'd1:    points = 16'd20;
      2'd2:    points = 16'd30;
      default: points = 16'd100;
    endcase
    sum        = {1'b0, score_reg} + points;
    score_next = score_reg;
    if (clear)
      score_next = '0;
    else if (hit)
      score_next = (sum > {1'b0, MAX_SCORE}) ? MAX_SCORE : sum[14:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      score_reg <= '0;
      dirty_reg <= 1'b0;
      timer_reg <= '0;
      draw_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      score_reg <= score_next;
      draw_reg  <= 1'b0;

      // A new event always wins, so activity during REQ/WAIT coalesces into one more draw.
      if (accept)
        dirty_reg <= 1'b1;
      else if (state_reg == REQ)
        dirty_reg <= 1'b0;
      else if (timed_out)
        dirty_reg <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (dirty_reg) begin
            state_reg <= REQ;
            draw_reg  <= 1'b1;
            busy_reg  <= 1'b1;
          end
        end
        REQ: begin
          timer_reg <= DONE_TIMEOUT;
          state_reg <= WAIT;
        end
        WAIT: begin
          if (done || timer_reg == 10'd0) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            timer_reg <= timer_reg - 10'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign scoreOut = score_reg;
  assign draw     = draw_reg;
  assign busy     = busy_reg;

`ifdef SCORE_KEEPER_HIGHSCORE_EN
  logic [14:0] high_reg;

  // Compares against the incoming score so the best value lands on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      high_reg <= '0;
    else if (score_next > high_reg)
      high_reg <= score_next;
  end

  assign highScoreOut = high_reg;
`else
  assign highScoreOut = '0;
`endif

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL have parameter MAX_SCORE, default 15'd9999: saturation ceiling for scoreOut.
REQ-002 SHALL have parameter DONE_TIMEOUT, default 10'd1023: cycles to wait for done before abandoning a redraw.
REQ-003 SHALL have port clock  input  1  system clock (CLOCK_50); all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port hit  input  1  one-cycle pulse: an alien was destroyed.
REQ-006 SHALL have port hitType  input  2  kind of alien hit, sampled only when hit=1.
REQ-007 SHALL have port clear  input  1  new-game pulse that zeroes the score.
REQ-008 SHALL have port done  input  1  completion pulse from the downstream score renderer.
REQ-009 SHALL have port scoreOut  output  15  current score; drives the renderer's scoreIn.
REQ-010 SHALL have port highScoreOut  output  15  best score since reset.
REQ-011 SHALL have port draw  output  1  one-cycle redraw request; drives the renderer's draw.
REQ-012 SHALL have port busy  output  1  high while a redraw is outstanding (REQ or WAIT).

Function
REQ-013 SHALL map hitType to points as follows: 0 -> 10, 1 -> 20, 2 -> 30, 3 -> 100.
REQ-014 SHALL register hit: on a cycle with hit=1, scoreOut SHALL equal min(scoreOut + points, MAX_SCORE) on the next edge; the sum SHALL be computed 16 bits wide so it cannot wrap.
REQ-015 SHALL give clear priority over hit in the same cycle: scoreOut <= 0, and the hit is discarded.
REQ-016 SHALL set the dirty flag on every accepted hit or clear, including a hit that leaves a saturated score unchanged.
REQ-017 SHALL implement FSM states IDLE, REQ and WAIT.
REQ-018 SHALL take the transition IDLE -> REQ when dirty=1.
REQ-019 SHALL, in REQ, assert draw=1 for exactly one cycle, clear dirty, load the timeout counter with DONE_TIMEOUT, and move to WAIT.
REQ-020 SHALL, in WAIT, decrement the timeout counter each cycle.
REQ-021 SHALL take the transition WAIT -> IDLE on done=1 or when the timeout counter reaches 0.
REQ-022 SHALL keep dirty set on timeout, so a fresh REQ follows at the next IDLE cycle.
REQ-023 SHALL coalesce hits and clears that occur during REQ or WAIT by setting dirty only, so exactly one further draw follows after WAIT exits.
REQ-024 SHALL ignore done in IDLE and REQ.
REQ-025 SHALL drive draw only in REQ, making the minimum spacing between draw pulses 3 cycles.
REQ-026 SHALL drive busy=1 exactly in REQ and WAIT.
REQ-027 SHALL make draw-to-done latency unbounded except by DONE_TIMEOUT.
REQ-028 SHALL make the hit-to-draw latency 2 cycles when the FSM is IDLE: hit sampled at edge n, dirty set at n+1, draw high during cycle n+2.

Reset
REQ-029 SHALL, while reset=1, immediately force the following: scoreOut=0, highScoreOut=0, draw=0, busy=0, dirty=0, timeout counter=0, state=IDLE.
REQ-030 SHALL abandon any in-progress redraw on reset mid-operation, emitting no draw after release.
REQ-031 SHALL require at least one hit or clear before the first draw after reset.

Configuration
REQ-032 SHALL use macro SCORE_KEEPER_HIGHSCORE_EN to select the high-score feature.
REQ-033 SHALL, when SCORE_KEEPER_HIGHSCORE_EN is defined, update highScoreOut to scoreOut's new value whenever that value exceeds highScoreOut, on the same edge that updates scoreOut.
REQ-034 SHALL, when SCORE_KEEPER_HIGHSCORE_EN is defined, leave highScoreOut unchanged by clear.
REQ-035 SHALL, when SCORE_KEEPER_HIGHSCORE_EN is not defined, tie highScoreOut to 0 with no register inferred.

Verification
REQ-036 SHALL cover this scenario: reset, then hit with hitType=1 in IDLE -> scoreOut=20 one cycle later; draw high for one cycle 2 cycles after the hit; busy=1 until done.
REQ-037 SHALL cover this scenario: score 9990, hit with hitType=3 -> scoreOut=9999; further hit with hitType=0 -> scoreOut stays 9999 and a draw is still issued.
REQ-038 SHALL cover this scenario: in WAIT, 3 hits with hitType=0 from score 0, then done -> scoreOut=30; exactly one extra draw after done.
REQ-039 SHALL cover this scenario: hit and clear in the same cycle at score 50 -> scoreOut=0, and one draw is issued.
REQ-040 SHALL cover this scenario: draw issued with done never asserted -> return to IDLE after 1024 WAIT cycles, then a second draw 2 cycles later.
REQ-041 SHALL cover this scenario: with SCORE_KEEPER_HIGHSCORE_EN defined, score 120 then clear -> highScoreOut=120 and scoreOut=0; without the macro, highScoreOut=0 throughout.
